inst_mem_rv64: RTL and testbench

- Byte-organised instruction memory for the RV64 fetch unit (IFU).
- Takes the 64-bit program counter and returns the 32-bit instruction at that address, combinationally.
- Asynchronous active-high reset reloads a fixed boot program image.
- A clocked word-write port lets the host overwrite instructions after reset.

---
 rtl/inst_mem_rv64.sv | 136 +++++++++++++
 tb/tb_inst_mem_rv64.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_rv64.sv
// inst_mem_rv64: byte-organised RV64 instruction memory.
//
// The fetch path is combinational: INST_CODE follows PC and the memory contents
// with zero latency and no output register. A single clocked word-write port
// lets the host patch instructions after reset. An asynchronous active-high
// RESET reloads a fixed eight-instruction boot program and clears the rest of
// the memory. RESET also blocks writes while it is high.
//
// Optional feature, macro INST_MEM_ALIGN_CHECK_EN:
//   defined     - MISALIGNED = |PC[1:0]. An in-range misaligned fetch returns
//                 NOP_WORD.
//   not defined - MISALIGNED is tied low. PC[1:0] is ignored and the aligned
//                 word is returned.
// Out-of-range fetches always return zero, whichever build is used.

module inst_mem_rv64 #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] PC,
  output logic [31:0] INST_CODE,
  input  logic        WR_EN,
  input  logic [63:0] WR_ADDR,
  input  logic [31:0] WR_DATA,
  output logic        OUT_OF_RANGE,
  output logic        MISALIGNED
);

  // Width of a byte index into the storage array.
  localparam int unsigned AW = $clog2(MEM_BYTES);

  // Size of the boot program in bytes (eight 32-bit instructions).
  localparam int unsigned BOOT_BYTES = 32;

  // Boot program packed as bytes. Byte A sits at bits [8A+7:8A], so each word
  // is stored little-endian exactly as it appears in memory.
  localparam logic [8*BOOT_BYTES-1:0] BOOT_IMAGE = {
    32'h0011_3423,  // 28: sd   x1,8(x2)
    32'h0020_C3B3,  // 24: xor  x7,x1,x2
    32'h0020_E333,  // 20: or   x6,x1,x2
    32'h0020_F2B3,  // 16: and  x5,x1,x2
    32'h4020_8233,  // 12: sub  x4,x1,x2
    32'h0020_81B3,  //  8: add  x3,x1,x2
    32'h00A0_0113,  //  4: addi x2,x0,10
    32'h0050_0093   //  0: addi x1,x0,5
  };

  // Byte storage
  logic [7:0] mem [MEM_BYTES];

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------

  // Word-aligned write address. The low two bits are dropped by masking so
  // that the full port is consumed.
  logic [63:0] wr_word_addr;
  logic        wr_in_range;
  logic        wr_fire;
  logic [AW-1:0] wr_base;

  // Decide whether this cycle's write lands inside the memory.
  always_comb begin
    wr_word_addr = WR_ADDR & ~64'h3;
    // Full 64-bit compare, so high address bits never alias into the array.
    wr_in_range  = (wr_word_addr < 64'(MEM_BYTES));
    wr_fire      = WR_EN && wr_in_range;
    wr_base      = wr_word_addr[AW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Storage: asynchronous boot-image load, clocked word write
  // ---------------------------------------------------------------------------

  // While RESET is high every clock edge also takes this branch. The image is
  // therefore held, and a write presented at a coincident edge is discarded.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(BOOT_BYTES); i++) begin
        mem[AW'(i)] <= BOOT_IMAGE[8*i +: 8];
      end
      for (int i = int'(BOOT_BYTES); i < int'(MEM_BYTES); i++) begin
        mem[AW'(i)] <= 8'h00;
      end
    end else if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        mem[wr_base + AW'(k)] <= WR_DATA[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  logic          rd_in_range;
  logic [AW-1:0] rd_base;
  logic [31:0]   rd_word;
  logic          align_fault;

  // Assemble the aligned word addressed by PC, little-endian.
  always_comb begin
    rd_in_range = (PC < 64'(MEM_BYTES));
    rd_base     = {PC[AW-1:2], 2'b00};
    rd_word     = {mem[rd_base + AW'(3)], mem[rd_base + AW'(2)],
                   mem[rd_base + AW'(1)], mem[rd_base]};
  end

`ifdef INST_MEM_ALIGN_CHECK_EN
  // Flag any fetch that is not on a 4-byte boundary.
  always_comb begin
    align_fault = |PC[1:0];
  end
`else
  // Without the check, low PC bits are simply ignored.
  always_comb begin
    align_fault = 1'b0;
  end
`endif

  // Select the fetch result. Out-of-range has priority over misalignment.
  always_comb begin
    OUT_OF_RANGE = !rd_in_range;
    MISALIGNED   = align_fault;
    if (!rd_in_range) begin
      INST_CODE = 32'h0000_0000;
    end else if (align_fault) begin
      INST_CODE = NOP_WORD;
    end else begin
      INST_CODE = rd_word;
    end
  end

endmodule

// File: tb/tb_inst_mem_rv64.sv
// tb_inst_mem_rv64: self-checking bench for inst_mem_rv64.
// Directed checks follow the design's reset, boundary, write and realignment
// cases. Random traffic is then checked against a word-level reference model.

module tb_inst_mem_rv64;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned NWORDS    = MEM_BYTES / 4;

  logic        CLK;
  logic        RESET;
  logic [63:0] PC;
  logic [31:0] INST_CODE;
  logic        WR_EN;
  logic [63:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic        OUT_OF_RANGE;
  logic        MISALIGNED;

  inst_mem_rv64 #(
    .MEM_BYTES(MEM_BYTES),
    .NOP_WORD (32'h0000_0013)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INST_CODE   (INST_CODE),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .OUT_OF_RANGE(OUT_OF_RANGE),
    .MISALIGNED  (MISALIGNED)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one 32-bit entry per instruction word.
  logic [31:0] ref_words [NWORDS];
  logic [31:0] boot [8];

  initial begin
    boot[0] = 32'h0050_0093; boot[1] = 32'h00A0_0113;
    boot[2] = 32'h0020_81B3; boot[3] = 32'h4020_8233;
    boot[4] = 32'h0020_F2B3; boot[5] = 32'h0020_E333;
    boot[6] = 32'h0020_C3B3; boot[7] = 32'h0011_3423;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NWORDS); i++) ref_words[i] = (i < 8) ? boot[i] : 32'h0;
  endtask

  function automatic logic exp_misaligned(input logic [63:0] pc);
`ifdef INST_MEM_ALIGN_CHECK_EN
    return pc[1] | pc[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    if (pc >= 64'(MEM_BYTES)) return 32'h0;
    if (exp_misaligned(pc)) return 32'h0000_0013;
    return ref_words[int'(pc / 64'd4)];
  endfunction

  // Compare all three outputs against the model for the current PC.
  task automatic check_outputs(input string tag);
    check_val({tag, ".inst"}, 64'(INST_CODE), 64'(exp_inst(PC)));
    check_val({tag, ".oor"}, 64'(OUT_OF_RANGE), 64'(PC >= 64'(MEM_BYTES)));
    check_val({tag, ".mis"}, 64'(MISALIGNED), 64'(exp_misaligned(PC)));
  endtask

  // One clocked write; the model follows only when the write should land.
  task automatic do_write(input logic [63:0] addr, input logic [31:0] data);
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = addr; WR_DATA = data;
    @(posedge CLK);
    #1;
    WR_EN = 1'b0;
    if (!RESET && (addr / 64'd4) < 64'(NWORDS)) ref_words[int'(addr / 64'd4)] = data;
  endtask

  // Short reset pulse between clock edges; the image must appear with no clock.
  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    #3;
    RESET = 1'b1;
    model_reset();
    PC = 64'd0;
    #1;
    check_val({tag, ".async"}, 64'(INST_CODE), 64'(boot[0]));
    #2;
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    RESET = 1'b0; PC = '0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    #20;
    RESET = 1'b1;
    model_reset();

    // Boot image visible while reset is held
    for (int i = 0; i < 8; i++) begin
      PC = 64'(4 * i);
      #1;
      check_val($sformatf("boot%0d", i), 64'(INST_CODE), 64'(boot[i]));
      check_val($sformatf("boot%0d.oor", i), 64'(OUT_OF_RANGE), 64'd0);
      #19;
    end

    // A write with reset held must not land
    do_write(64'd0, 32'h1111_2222);
    PC = 64'd0; #1;
    check_val("wr_in_reset", 64'(INST_CODE), 64'h0050_0093);
    @(negedge CLK);
    RESET = 1'b0;

    // Range boundary
    PC = 64'd252; #1; check_outputs("pc252");
    check_val("pc252.zero", 64'(INST_CODE), 64'd0);
    PC = 64'd256; #1; check_outputs("pc256");
    check_val("pc256.oor1", 64'(OUT_OF_RANGE), 64'd1);
    PC = 64'h8000_0000_0000_0000; #1; check_outputs("pc_hi");
    check_val("pc_hi.oor1", 64'(OUT_OF_RANGE), 64'd1);
    PC = 64'h0000_0001_0000_0004; #1; check_outputs("pc_alias");

    // Write then read, unaligned write address, out-of-range write
    do_write(64'd40, 32'hDEAD_BEEF);
    PC = 64'd40; #1; check_val("wr40", 64'(INST_CODE), 64'hDEAD_BEEF);
    do_write(64'd43, 32'h1234_5678);
    PC = 64'd40; #1; check_val("wr43", 64'(INST_CODE), 64'h1234_5678);
    do_write(64'd300, 32'hFFFF_FFFF);
    PC = 64'd40; #1; check_val("wr300.w40", 64'(INST_CODE), 64'h1234_5678);
    PC = 64'd300; #1; check_outputs("wr300");
    do_write(64'h1_0000_0028, 32'hAAAA_5555);
    PC = 64'd40; #1; check_val("wr_alias", 64'(INST_CODE), 64'h1234_5678);

    // Read-during-write: old word before the edge, new word after
    @(negedge CLK);
    PC = 64'd44; WR_EN = 1'b1; WR_ADDR = 64'd44; WR_DATA = 32'hA5A5_0F0F;
    #1;
    check_val("rdw.old", 64'(INST_CODE), 64'd0);
    @(posedge CLK); #1;
    WR_EN = 1'b0;
    ref_words[11] = 32'hA5A5_0F0F;
    check_val("rdw.new", 64'(INST_CODE), 64'hA5A5_0F0F);

    // Reset mid-operation restores the image over written data
    do_write(64'd0, 32'hCAFE_F00D);
    PC = 64'd0; #1; check_val("cafe", 64'(INST_CODE), 64'hCAFE_F00D);
    pulse_reset("rst_mid");
    PC = 64'd40; #1; check_outputs("rst_mid.w40");

    // Alignment behaviour
    PC = 64'd6; #1; check_outputs("pc6");
`ifdef INST_MEM_ALIGN_CHECK_EN
    check_val("pc6.nop", 64'(INST_CODE), 64'h0000_0013);
    PC = 64'd258; #1; check_val("pc258.inst", 64'(INST_CODE), 64'd0);
`else
    check_val("pc6.word", 64'(INST_CODE), 64'h00A0_0113);
`endif

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      int unsigned op;
      logic [63:0] a;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a = (op == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 320));
        do_write(a, $urandom());
      end else if (op == 4 && $urandom_range(0, 7) == 0) begin
        pulse_reset($sformatf("rnd%0d", it));
      end
      case ($urandom_range(0, 3))
        0:       PC = {$urandom(), $urandom()};
        1:       PC = 64'($urandom_range(248, 264));
        default: PC = 64'($urandom_range(0, 255));
      endcase
      #1;
      check_outputs($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
